// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an incoming PWM waveform.
// The input is synchronized, rising edges start each period, and a missing
// rising edge after TIMEOUT cycles reports a stuck-low/stuck-high input.
module pwm_capture #(
    parameter int WIDTH   = 11,
    parameter int TIMEOUT = 4095
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] duty_out,
    output logic [WIDTH:0]   period_out,
    output logic             valid,
    output logic             timeout,
    output logic             locked
);

    localparam logic [WIDTH-1:0] HIGH_MAX = '1;
    localparam logic [WIDTH-1:0] HIGH_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   PER_ONE  = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   PER_TO   = (WIDTH+1)'(TIMEOUT);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic             r_s0;
    logic             r_s1;
    logic             r_p;
    logic             w_rise;

    logic [WIDTH:0]   r_period_cnt;
    logic [WIDTH-1:0] r_high_cnt;

    logic             w_arm;
    logic             w_update;
    logic             w_tmo;

    // Saturating high-time increment: adds the synchronized level, never wraps.
    function automatic logic [WIDTH-1:0] f_high_inc(input logic [WIDTH-1:0] cnt,
                                                    input logic             lvl);
        if (lvl && (cnt != HIGH_MAX))
            return cnt + HIGH_ONE;
        return cnt;
    endfunction

    // Level reported when the input stops toggling: all-ones if stuck high.
    function automatic logic [WIDTH-1:0] f_stuck_duty(input logic lvl);
        return lvl ? HIGH_MAX : '0;
    endfunction

    assign w_rise = r_s1 & ~r_p;

    // Two-flop synchronizer plus history flop for rising-edge detection.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_s0 <= 1'b0;
            r_s1 <= 1'b0;
            r_p  <= 1'b0;
        end else begin
            r_s0 <= pwm_in;
            r_s1 <= r_s0;
            r_p  <= r_s1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_in) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // FSM next-state logic: a rise arms measurement, a timeout drops back to idle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_rise) w_state_next = ST_MEASURE;
            ST_MEASURE: if (!w_rise && (r_period_cnt == PER_TO)) w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // FSM output decode: a rise in MEASURE beats a coincident timeout.
    always_comb begin
        w_arm    = 1'b0;
        w_update = 1'b0;
        w_tmo    = 1'b0;
        case (r_state)
            ST_IDLE:    w_arm    = w_rise;
            ST_MEASURE: begin
                w_update = w_rise;
                w_tmo    = !w_rise && (r_period_cnt == PER_TO);
            end
            default: ;
        endcase
    end

    // Counters and registered results; the first partial period after arming is discarded.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_period_cnt <= '0;
            r_high_cnt   <= '0;
            duty_out     <= '0;
            period_out   <= '0;
            valid        <= 1'b0;
            timeout      <= 1'b0;
            locked       <= 1'b0;
        end else begin
            valid   <= 1'b0;
            timeout <= 1'b0;
            if (w_arm) begin
                r_period_cnt <= PER_ONE;
                r_high_cnt   <= HIGH_ONE;
            end else if (w_update) begin
                duty_out     <= r_high_cnt;
                period_out   <= r_period_cnt;
                valid        <= 1'b1;
                locked       <= 1'b1;
                r_period_cnt <= PER_ONE;
                r_high_cnt   <= HIGH_ONE;
            end else if (w_tmo) begin
                duty_out     <= f_stuck_duty(r_s1);
                period_out   <= '0;
                valid        <= 1'b1;
                timeout      <= 1'b1;
                locked       <= 1'b0;
                r_period_cnt <= '0;
                r_high_cnt   <= '0;
            end else if (r_state == ST_MEASURE) begin
                r_period_cnt <= r_period_cnt + PER_ONE;
                r_high_cnt   <= f_high_inc(r_high_cnt, r_s1);
            end else begin
                r_period_cnt <= '0;
                r_high_cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a Modulo_PWM-style generator (11-bit
// free-running counter, high while counter < D) or direct drive feeds pwm_in.
module tb_pwm_capture;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        pwm_in;
    logic [10:0] duty_out;
    logic [11:0] period_out;
    logic        valid;
    logic        timeout;
    logic        locked;

    int checks = 0;
    int errors = 0;

    logic        gen_en = 1'b0;
    logic [10:0] gen_cnt = '0;
    logic [10:0] gen_d = '0;

    int n;
    int extra_valid;
    int extra_tmo;

    pwm_capture #(.WIDTH(11), .TIMEOUT(4095)) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .pwm_in     (pwm_in),
        .duty_out   (duty_out),
        .period_out (period_out),
        .valid      (valid),
        .timeout    (timeout),
        .locked     (locked)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; outputs settle by #1, then the generator advances.
    task automatic tick();
        @(posedge clk_in);
        #1;
        if (gen_en) begin
            gen_cnt = gen_cnt + 11'd1;
            pwm_in  = (gen_cnt < gen_d);
        end
    endtask

    task automatic run_until_valid(input int max, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!valid && cyc < max);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_duty"},   32'(duty_out),   32'd0);
        chk({tag, "_period"}, 32'(period_out), 32'd0);
        chk({tag, "_valid"},  32'(valid),      32'd0);
        chk({tag, "_tmo"},    32'(timeout),    32'd0);
        chk({tag, "_locked"}, 32'(locked),     32'd0);
    endtask

    task automatic chk_out(input string tag, input int d, input int p,
                           input int to, input int lk);
        chk({tag, "_valid"},  32'(valid),      32'd1);
        chk({tag, "_duty"},   32'(duty_out),   32'(d));
        chk({tag, "_period"}, 32'(period_out), 32'(p));
        chk({tag, "_tmo"},    32'(timeout),    32'(to));
        chk({tag, "_locked"}, 32'(locked),     32'(lk));
    endtask

    initial begin
        reset  = 1'b1;
        pwm_in = 1'b0;
        tick(); tick(); tick();
        chk_zero("rst");

        // Steady duty D=512
        reset   = 1'b0;
        gen_d   = 11'd512;
        gen_cnt = '0;
        gen_en  = 1'b1;
        pwm_in  = 1'b1;
        run_until_valid(6000, n);
        chk("first_valid_cyc", 32'(n), 32'd2051);
        chk_out("steady1", 512, 2048, 0, 1);
        run_until_valid(6000, n);
        chk("steady2_cyc", 32'(n), 32'd2048);
        chk_out("steady2", 512, 2048, 0, 1);

        // Duty change 512 -> 1500 while the output is high
        repeat (197) tick();
        chk("gen_pos", 32'(gen_cnt), 32'd200);
        gen_d = 11'd1500;
        run_until_valid(6000, n);
        chk("step_cyc", 32'(n), 32'd1851);
        chk_out("step", 1500, 2048, 0, 1);
        run_until_valid(6000, n);
        chk("d1500_cyc", 32'(n), 32'd2048);
        chk_out("d1500", 1500, 2048, 0, 1);

        // Stuck low
        gen_d = 11'd0;
        run_until_valid(6000, n);
        chk("lo_to_cyc", 32'(n), 32'd4095);
        chk_out("lo_to", 0, 0, 1, 0);
        tick();
        chk("lo_after_valid", 32'(valid), 32'd0);
        chk("lo_after_tmo", 32'(timeout), 32'd0);

        // Stuck high: rise from IDLE only arms, then timeout
        gen_en = 1'b0;
        pwm_in = 1'b1;
        run_until_valid(6000, n);
        chk("hi_to_cyc", 32'(n), 32'd4098);
        chk_out("hi_to", 2047, 0, 1, 0);

        // Re-arm, lock on a 1000-cycle period, then a rise colliding with timeout
        pwm_in = 1'b0;
        repeat (5) tick();
        pwm_in = 1'b1;
        extra_valid = 0;
        extra_tmo   = 0;
        for (int i = 1; i <= 5098; i++) begin
            tick();
            if (timeout) extra_tmo++;
            if (i == 1003) chk_out("lock1000", 100, 1000, 0, 1);
            else if (i == 5098) chk_out("collide", 50, 4095, 0, 1);
            else if (valid) extra_valid++;
            if (i == 100)  pwm_in = 1'b0;
            if (i == 1000) pwm_in = 1'b1;
            if (i == 1050) pwm_in = 1'b0;
            if (i == 5095) pwm_in = 1'b1;
        end
        chk("rearm_extra_valid", 32'(extra_valid), 32'd0);
        chk("rearm_any_tmo", 32'(extra_tmo), 32'd0);

        // Reset mid-period of a D=300 stream
        gen_d   = 11'd300;
        gen_cnt = '0;
        gen_en  = 1'b1;
        run_until_valid(6000, n);
        run_until_valid(6000, n);
        chk("d300_cyc", 32'(n), 32'd2048);
        chk_out("d300", 300, 2048, 0, 1);
        repeat (697) tick();
        chk("gen_pos700", 32'(gen_cnt), 32'd700);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_zero("midrst");
        run_until_valid(8000, n);
        chk("post_rst_cyc", 32'(n), 32'd3398);
        chk_out("post_rst", 300, 2048, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
